// File: rtl/filter_bank_sched.sv
// Filter bank scheduler: walks each accepted window through the enabled filters,
// issuing one MAC job per filter and reporting each result plus frame completion.
module filter_bank_sched #(
  parameter int N_FILTERS = 4,
  parameter int PIX_FRAME = 3844,
  parameter int CNT_W     = 12,
  localparam int IDX_W    = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N_FILTERS-1:0] filter_mask,
  input  logic                 win_valid,
  output logic                 win_ready,
  output logic [IDX_W-1:0]     filter_used,
  output logic                 mac_start,
  input  logic                 mac_done,
  output logic                 res_valid,
  output logic [IDX_W-1:0]     res_filter,
  output logic                 res_last,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_WIN = 3'd1;
  localparam logic [2:0] ISSUE    = 3'd2;
  localparam logic [2:0] WAIT_MAC = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]           state;
  logic [N_FILTERS-1:0] mask_q;
  logic [CNT_W-1:0]     pix_cnt;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     first_idx;
  logic [IDX_W-1:0]     next_idx;
  logic                 next_found;
  logic                 last_win;

  // Scanning from the top down leaves the lowest qualifying bit as the final assignment.
  always_comb begin
    first_idx  = '0;
    next_idx   = '0;
    next_found = 1'b0;
    for (int f = N_FILTERS - 1; f >= 0; f--) begin
      if (mask_q[f]) begin
        first_idx = IDX_W'(f);
      end
      if (mask_q[f] && (f > int'(idx))) begin
        next_idx   = IDX_W'(f);
        next_found = 1'b1;
      end
    end
  end

  assign last_win    = (pix_cnt == CNT_W'(PIX_FRAME - 1));
  assign win_ready   = (state == WAIT_WIN);
  assign mac_start   = (state == ISSUE);
  assign busy        = (state != IDLE);
  assign frame_done  = (state == DONE);
  assign filter_used = idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      mask_q     <= '0;
      pix_cnt    <= '0;
      idx        <= '0;
      res_valid  <= 1'b0;
      res_filter <= '0;
      res_last   <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mask_q  <= filter_mask;
            pix_cnt <= '0;
            state   <= WAIT_WIN;
          end
        end
        WAIT_WIN: begin
          if (win_valid) begin
            if (mask_q != '0) begin
              idx   <= first_idx;
              state <= ISSUE;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
              state   <= last_win ? DONE : WAIT_WIN;
            end
          end
        end
        ISSUE: state <= WAIT_MAC;
        WAIT_MAC: begin
          // idx only moves on the way back into ISSUE, so the mux select stays put here.
          if (mac_done) begin
            res_valid  <= 1'b1;
            res_filter <= idx;
            res_last   <= !next_found;
            if (next_found) begin
              idx   <= next_idx;
              state <= ISSUE;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
              state   <= last_win ? DONE : WAIT_WIN;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_bank_sched.sv
// Bench for filter_bank_sched: transaction-level model checked every cycle, plus
// directed scenarios with hand-computed pulse counts and timing.
module tb_filter_bank_sched;

  localparam int NF   = 4;
  localparam int PIXA = 2;
  localparam int PIXB = 3;

  logic clk = 1'b0;
  logic rst_n, start, win_valid, mac_done, mac_done_auto, mac_done_man;
  logic [3:0] filter_mask;
  logic win_ready, mac_start, res_valid, res_last, busy, frame_done;
  logic [1:0] filter_used, res_filter;

  logic b_start, b_win_valid, b_win_ready, b_mac_start, b_res_valid, b_res_last, b_busy, b_frame_done;
  logic [3:0] b_mask;
  logic [1:0] b_filter_used, b_res_filter;

  int checks = 0;
  int passes = 0;
  int resp_lat = 3;
  logic resp_en = 1'b0;

  // Model state, owned by the compare process.
  logic m_active, m_issue_due, m_out, m_res_due, m_res_last, m_fd_due;
  logic [1:0] m_cur, m_res_f;
  logic [3:0] m_mask;
  int m_win_done;
  int m_jobs[$];

  // DUT event tallies, owned by the compare process.
  int n_start = 0, n_res = 0, n_last = 0, n_fd = 0, n_bad_last = 0;
  int sel_cnt[4] = '{0, 0, 0, 0};
  int s_start, s_res, s_last, s_fd, s_bad_last;
  int s_sel[4];

  assign mac_done = mac_done_auto | mac_done_man;

  always #5 clk = ~clk;

  filter_bank_sched #(.N_FILTERS(NF), .PIX_FRAME(PIXA), .CNT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .filter_mask(filter_mask),
    .win_valid(win_valid), .win_ready(win_ready), .filter_used(filter_used),
    .mac_start(mac_start), .mac_done(mac_done), .res_valid(res_valid),
    .res_filter(res_filter), .res_last(res_last), .busy(busy), .frame_done(frame_done)
  );

  filter_bank_sched #(.N_FILTERS(NF), .PIX_FRAME(PIXB), .CNT_W(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .filter_mask(b_mask),
    .win_valid(b_win_valid), .win_ready(b_win_ready), .filter_used(b_filter_used),
    .mac_start(b_mac_start), .mac_done(1'b0), .res_valid(b_res_valid),
    .res_filter(b_res_filter), .res_last(b_res_last), .busy(b_busy), .frame_done(b_frame_done)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
  endtask

  task automatic snap();
    s_start = n_start; s_res = n_res; s_last = n_last; s_fd = n_fd; s_bad_last = n_bad_last;
    for (int i = 0; i < 4; i++) s_sel[i] = sel_cnt[i];
  endtask

  task automatic startFrame(input logic [3:0] mask);
    start = 1'b1;
    filter_mask = mask;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feedWindow(input int gap);
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    win_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!win_ready && t < 200);
    checkOutput("window_accepted", win_ready, 1);
    @(posedge clk); #1;
    win_valid = 1'b0;
  endtask

  task automatic waitFrameDone(input int bound);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (!frame_done && t < bound);
    checkOutput("frame_done_seen", frame_done, 1);
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input int gap, input bit toggle);
    startFrame(mask);
    for (int w = 0; w < PIXA; w++) begin
      feedWindow(gap);
      if (toggle && w == 0) filter_mask = ~filter_mask;
    end
    waitFrameDone(400);
  endtask

  // MAC stand-in: answers each mac_start with mac_done resp_lat cycles later.
  initial begin : responder
    mac_done_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (mac_start && resp_en && rst_n) begin
        repeat (resp_lat) @(posedge clk);
        #1 mac_done_auto = 1'b1;
        @(posedge clk); #1 mac_done_auto = 1'b0;
      end
    end
  end

  // Expected behaviour expressed as job lists and latency rules rather than states.
  initial begin : compare
    logic e_ready;
    {m_active, m_issue_due, m_out, m_res_due, m_res_last, m_fd_due} = '0;
    m_cur = '0; m_res_f = '0; m_mask = '0; m_win_done = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_ready = m_active && !m_fd_due && !m_issue_due && !m_out && (m_jobs.size() == 0);
      checkOutput("busy", busy, m_active);
      checkOutput("win_ready", win_ready, e_ready);
      checkOutput("mac_start", mac_start, m_issue_due);
      checkOutput("frame_done", frame_done, m_fd_due);
      checkOutput("res_valid", res_valid, m_res_due);
      if (m_res_due) begin
        checkOutput("res_filter", res_filter, m_res_f);
        checkOutput("res_last", res_last, m_res_last);
      end
      if (m_issue_due && m_jobs.size() > 0) checkOutput("filter_used_issue", filter_used, m_jobs[0]);
      if (m_out) checkOutput("filter_used_hold", filter_used, m_cur);
      if (mac_start) checkOutput("mac_done_with_start", mac_done, 0);

      if (mac_start) begin n_start++; sel_cnt[filter_used]++; end
      if (res_valid) n_res++;
      if (res_valid && res_last) n_last++;
      if (res_valid && res_last && res_filter != 2'd3) n_bad_last++;
      if (frame_done) n_fd++;

      if (!rst_n) begin
        {m_active, m_issue_due, m_out, m_res_due, m_res_last, m_fd_due} = '0;
        m_jobs.delete();
        m_mask = '0;
        m_win_done = 0;
      end else begin
        m_res_due = 1'b0;
        if (m_fd_due) begin
          m_fd_due = 1'b0;
          m_active = 1'b0;
        end else if (m_issue_due) begin
          m_issue_due = 1'b0;
          m_out = 1'b1;
          m_cur = 2'(m_jobs.pop_front());
        end else if (m_out) begin
          if (mac_done) begin
            m_out = 1'b0;
            m_res_due = 1'b1;
            m_res_f = m_cur;
            m_res_last = (m_jobs.size() == 0);
            if (m_jobs.size() > 0) m_issue_due = 1'b1;
            else begin
              m_win_done++;
              if (m_win_done == PIXA) m_fd_due = 1'b1;
            end
          end
        end else if (e_ready && win_valid) begin
          if (m_mask != 4'b0000) begin
            for (int f = 0; f < NF; f++) if (m_mask[f]) m_jobs.push_back(f);
            m_issue_due = 1'b1;
          end else begin
            m_win_done++;
            if (m_win_done == PIXA) m_fd_due = 1'b1;
          end
        end else if (!m_active && start) begin
          m_active = 1'b1;
          m_mask = filter_mask;
          m_win_done = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    int acc, acc_cyc, fd_cyc, nfd, bad;
    rst_n = 1'b0; start = 1'b0; filter_mask = '0; win_valid = 1'b0; mac_done_man = 1'b0;
    b_start = 1'b0; b_mask = '0; b_win_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_win_ready", win_ready, 0);
    checkOutput("rst_mac_start", mac_start, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_filter_used", filter_used, 0);
    checkOutput("rst_res_filter", res_filter, 0);
    checkOutput("rst_res_last", res_last, 0);
    checkOutput("rst_b_busy", b_busy, 0);
    checkOutput("rst_b_filter_used", b_filter_used, 0);
    checkOutput("rst_b_res_filter", b_res_filter, 0);
    checkOutput("rst_b_res_last", b_res_last, 0);
    @(posedge clk); #1;

    $display("[TB] reset while a MAC job is outstanding");
    resp_en = 1'b0;
    startFrame(4'b1111);
    feedWindow(0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_win_ready", win_ready, 0);
    checkOutput("midrst_mac_start", mac_start, 0);
    checkOutput("midrst_res_valid", res_valid, 0);
    @(posedge clk); #1 mac_done_man = 1'b1;
    @(posedge clk); #1 mac_done_man = 1'b0;
    @(negedge clk);
    checkOutput("late_done_res_valid", res_valid, 0);
    checkOutput("late_done_busy", busy, 0);
    @(posedge clk); #1;

    $display("[TB] full mask, MAC latency 3");
    resp_lat = 3; resp_en = 1'b1;
    snap();
    applyStimulus(4'b1111, 0, 1'b0);
    checkOutput("full_mac_starts", n_start - s_start, 8);
    checkOutput("full_results", n_res - s_res, 8);
    checkOutput("full_last", n_last - s_last, 2);
    checkOutput("full_last_not3", n_bad_last - s_bad_last, 0);
    checkOutput("full_frame_done", n_fd - s_fd, 1);
    for (int i = 0; i < 4; i++) checkOutput("full_sel", sel_cnt[i] - s_sel[i], 2);

    $display("[TB] sparse mask 1010");
    snap();
    applyStimulus(4'b1010, 0, 1'b0);
    checkOutput("sparse_sel0", sel_cnt[0] - s_sel[0], 0);
    checkOutput("sparse_sel1", sel_cnt[1] - s_sel[1], 2);
    checkOutput("sparse_sel2", sel_cnt[2] - s_sel[2], 0);
    checkOutput("sparse_sel3", sel_cnt[3] - s_sel[3], 2);
    checkOutput("sparse_last", n_last - s_last, 2);
    checkOutput("sparse_last_not3", n_bad_last - s_bad_last, 0);

    $display("[TB] empty mask, frame of 3 windows");
    b_start = 1'b1; b_mask = 4'b0000;
    @(posedge clk); #1;
    b_start = 1'b0; b_win_valid = 1'b1;
    acc = 0; acc_cyc = -1; fd_cyc = -1; nfd = 0; bad = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (b_mac_start || b_res_valid) bad++;
      if (b_win_valid && b_win_ready) begin acc++; acc_cyc = cyc; end
      if (b_frame_done) begin nfd++; fd_cyc = cyc; end
      @(posedge clk); #1;
    end
    b_win_valid = 1'b0;
    checkOutput("empty_accepts", acc, 3);
    checkOutput("empty_last_accept_cycle", acc_cyc, 2);
    checkOutput("empty_frame_done_cycle", fd_cyc, 3);
    checkOutput("empty_frame_done_count", nfd, 1);
    checkOutput("empty_no_mac", bad, 0);
    checkOutput("empty_idle_after", b_busy, 0);

    $display("[TB] stalls: gapped windows, slow MAC, mask toggled mid-frame");
    resp_lat = 10;
    snap();
    applyStimulus(4'b1111, 5, 1'b1);
    checkOutput("stall_mac_starts", n_start - s_start, 8);
    checkOutput("stall_results", n_res - s_res, 8);
    checkOutput("stall_frame_done", n_fd - s_fd, 1);

    $display("[TB] spurious mac_done and start while busy");
    resp_lat = 2;
    snap();
    startFrame(4'b1010);
    mac_done_man = 1'b1; start = 1'b1; filter_mask = 4'b1111;
    repeat (2) begin @(posedge clk); #1; end
    mac_done_man = 1'b0; start = 1'b0;
    @(negedge clk);
    checkOutput("spur_busy", busy, 1);
    checkOutput("spur_win_ready", win_ready, 1);
    checkOutput("spur_no_result", n_res - s_res, 0);
    @(posedge clk); #1;
    for (int w = 0; w < PIXA; w++) feedWindow(1);
    waitFrameDone(400);
    checkOutput("spur_results", n_res - s_res, 4);
    checkOutput("spur_mac_starts", n_start - s_start, 4);
    checkOutput("spur_frame_done", n_fd - s_fd, 1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
